led_pattern_seq: RTL

//  Parametrised LED pattern sequencer. Steps through a writable table of
//  CH-bit LED patterns at a programmable rate, in loop, one-shot or

---
 rtl/led_seq_pkg.sv | 27 ++
 rtl/led_pattern_seq_if.sv | 41 ++++
 rtl/led_tick_gen.sv | 37 +++
 rtl/led_pattern_seq.sv | 136 +++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_seq_pkg
//  Description : Shared mode encodings, sequencer state type and LEN clamp
//                helper for the LED pattern sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package led_seq_pkg;

    localparam logic [1:0] MODE_LOOP     = 2'd0;
    localparam logic [1:0] MODE_ONESHOT  = 2'd1;
    localparam logic [1:0] MODE_PINGPONG = 2'd2;

    // ST_STOPPED is the only non-busy state; direction lives in UP/DOWN.
    typedef enum logic [1:0] {
        ST_UP      = 2'd0,
        ST_DOWN    = 2'd1,
        ST_STOPPED = 2'd2
    } seq_state_t;

    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned last);
        return (len > last) ? last : len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_pattern_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : led_pattern_seq_if
//  Description : Control / status bundle between a control source and the
//                LED pattern sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
interface led_pattern_seq_if #(
    parameter int CH    = 3,
    parameter int DEPTH = 8,
    parameter int PW    = 24
);
    localparam int c_aw = $clog2(DEPTH);

    logic              i_en;
    logic [1:0]        i_mode;
    logic [c_aw-1:0]   i_len;
    logic [PW-1:0]     i_div;
    logic              i_restart;
    logic              i_wr_en;
    logic [c_aw-1:0]   i_wr_addr;
    logic [CH-1:0]     i_wr_data;
    logic [CH-1:0]     o_led;
    logic [c_aw-1:0]   o_step;
    logic              o_busy;
    logic              o_done;

    modport master (
        output i_en, i_mode, i_len, i_div, i_restart,
        output i_wr_en, i_wr_addr, i_wr_data,
        input  o_led, o_step, o_busy, o_done
    );

    modport slave (
        input  i_en, i_mode, i_len, i_div, i_restart,
        input  i_wr_en, i_wr_addr, i_wr_data,
        output o_led, o_step, o_busy, o_done
    );

endinterface
`default_nettype wire

// File: rtl/led_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : led_tick_gen
//  Description : Programmable prescaler; one-cycle tick every DIV+1 enabled
//                cycles, synchronous clear.
//  Revision    : 1.0  initial release
// ============================================================================
module led_tick_gen #(
    parameter int PW = 24
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          i_en,
    input  wire logic          i_clear,
    input  wire logic [PW-1:0] i_div,
    output logic               o_tick
);

    logic [PW-1:0] r_cnt;
    logic          w_hit;

    // Equality only: if DIV drops below the count, it wraps through max.
    assign w_hit  = (r_cnt == i_div);
    assign o_tick = i_en & ~i_clear & w_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_hit ? '0 : r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_pattern_seq.sv
`default_nettype none
// ============================================================================
//  Module      : led_pattern_seq
//  Description : Steps through a writable CH-bit pattern table at a
//                programmable rate in loop, one-shot or ping-pong mode.
//  Revision    : 1.0  initial release
// ============================================================================
module led_pattern_seq
    import led_seq_pkg::*;
#(
    parameter int CH         = 3,
    parameter int DEPTH      = 8,
    parameter int PW         = 24,
    parameter int ACTIVE_LOW = 1
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    led_pattern_seq_if.slave  io_bus
);

    localparam int            c_aw  = $clog2(DEPTH);
    localparam logic [CH-1:0] c_off = (ACTIVE_LOW != 0) ? {CH{1'b1}} : {CH{1'b0}};

    logic [CH-1:0]   r_table [DEPTH];
    logic [c_aw-1:0] r_idx;
    seq_state_t      r_state;
    logic            r_done;
    logic [CH-1:0]   r_led;

    logic [c_aw-1:0] w_idx_nxt;
    seq_state_t      w_state_nxt;
    logic            w_done_nxt;
    logic            w_busy;
    logic            w_tick;
    logic [1:0]      w_mode;
    logic [c_aw-1:0] w_last;
    logic            w_end;

    assign w_busy = (r_state != ST_STOPPED);
    assign w_mode = (io_bus.i_mode == 2'd3) ? MODE_LOOP : io_bus.i_mode;
    assign w_last = c_aw'(clamp_len(32'(io_bus.i_len), 32'(DEPTH - 1)));
    // >= rather than == so a LEN lowered below idx still ends the pass.
    assign w_end  = (r_idx >= w_last);

    led_tick_gen #(
        .PW (PW)
    ) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (io_bus.i_en & w_busy),
        .i_clear (io_bus.i_restart),
        .i_div   (io_bus.i_div),
        .o_tick  (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_done_nxt  = 1'b0;
        if (io_bus.i_restart) begin
            w_idx_nxt   = '0;
            w_state_nxt = ST_UP;
        end else begin
            if (r_state == ST_DOWN && w_mode != MODE_PINGPONG) begin
                w_state_nxt = ST_UP;
            end
            if (r_state == ST_STOPPED && w_mode != MODE_ONESHOT) begin
                w_state_nxt = ST_UP;
            end
            if (w_tick) begin
                case (w_mode)
                    MODE_ONESHOT: begin
                        if (w_end) begin
                            w_state_nxt = ST_STOPPED;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_idx_nxt = r_idx + 1'b1;
                        end
                    end
                    MODE_PINGPONG: begin
                        if (w_last == '0) begin
                            w_idx_nxt   = '0;
                            w_state_nxt = ST_UP;
                        end else if (r_state == ST_DOWN) begin
                            if (r_idx == '0) begin
                                w_idx_nxt   = c_aw'(1);
                                w_state_nxt = ST_UP;
                            end else begin
                                w_idx_nxt = r_idx - 1'b1;
                            end
                        end else if (w_end) begin
                            w_idx_nxt   = r_idx - 1'b1;
                            w_state_nxt = ST_DOWN;
                        end else begin
                            w_idx_nxt = r_idx + 1'b1;
                        end
                    end
                    default: begin
                        w_idx_nxt = w_end ? '0 : r_idx + 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_UP;
            r_idx   <= '0;
            r_done  <= 1'b0;
            r_led   <= c_off;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_done  <= w_done_nxt;
            r_led   <= r_table[r_idx] ^ c_off;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= '0;
            end
        end else if (io_bus.i_wr_en) begin
            r_table[io_bus.i_wr_addr] <= io_bus.i_wr_data;
        end
    end

    assign io_bus.o_led  = r_led;
    assign io_bus.o_step = r_idx;
    assign io_bus.o_busy = w_busy;
    assign io_bus.o_done = r_done;

endmodule
`default_nettype wire
